// File: rtl/io_conditioner.sv
// io_conditioner: per-channel synchroniser, polarity normaliser and debouncer for raw board
// pins, with one-cycle rise/fall pulses and a stretched reset request driven by one channel.
//
// Ports:
//   i_clk         system clock; all logic in this domain
//   i_rst         synchronous active-high reset
//   i_in_raw      [N] asynchronous raw pins
//   o_level       [N] debounced, active-high channel state
//   o_rise        [N] one-cycle pulse on level 0->1
//   o_fall        [N] one-cycle pulse on level 1->0
//   o_any_change  OR of all rise/fall pulses
//   o_rst_req     stretched active-high reset request
module io_conditioner #(
   parameter int unsigned   N               = 12,
   parameter int unsigned   SYNC_STAGES     = 2,
   parameter int unsigned   DEBOUNCE_CYCLES = 500000,
   parameter logic [N-1:0]  ACTIVE_LOW      = 12'h003,
   parameter int unsigned   RST_CH          = 0,
   parameter int unsigned   RST_STRETCH     = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_in_raw,
   output logic [N-1:0] o_level,
   output logic [N-1:0] o_rise,
   output logic [N-1:0] o_fall,
   output logic         o_any_change,
   output logic         o_rst_req
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned SW = $clog2(RST_STRETCH + 1);
   localparam logic [DW-1:0] DbMax = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] StMax = SW'(RST_STRETCH - 1);

   typedef enum logic [1:0] {
      StPwr,
      StIdle,
      StHold
   } state_e;

   // Channel datapath
   logic [N-1:0][SYNC_STAGES-1:0] r_sync;
   logic [N-1:0][DW-1:0]          r_cnt;
   logic [N-1:0][DW-1:0]          w_cnt_nxt;
   logic [N-1:0]                  r_level;
   logic [N-1:0]                  r_rise;
   logic [N-1:0]                  r_fall;
   logic [N-1:0]                  w_s;
   logic [N-1:0]                  w_level_nxt;
   logic [N-1:0]                  w_rise_nxt;
   logic [N-1:0]                  w_fall_nxt;

   // Reset-request FSM
   state_e        r_state;
   state_e        w_state_nxt;
   logic [SW-1:0] r_stretch;
   logic [SW-1:0] w_stretch_nxt;

   always_comb begin
      w_s         = '0;
      w_level_nxt = r_level;
      w_cnt_nxt   = '0;
      w_rise_nxt  = '0;
      w_fall_nxt  = '0;
      for (int i = 0; i < N; i++) begin
         w_s[i] = r_sync[i][SYNC_STAGES-1] ^ ACTIVE_LOW[i];
         // Any sample equal to the current level clears the count, so only an unbroken
         // run of differing samples is ever accepted.
         if (w_s[i] != r_level[i]) begin
            if (r_cnt[i] == DbMax) begin
               w_level_nxt[i] = w_s[i];
               w_rise_nxt[i]  = w_s[i];
               w_fall_nxt[i]  = ~w_s[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // Chains preload the inactive pin value so no spurious edge follows reset.
         for (int i = 0; i < N; i++) begin
            r_sync[i] <= {SYNC_STAGES{ACTIVE_LOW[i]}};
         end
         r_cnt   <= '0;
         r_level <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_in_raw[i]};
         end
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StPwr;
         r_stretch <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_stretch <= w_stretch_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_stretch_nxt = r_stretch;
      case (r_state)
         StPwr: begin
            if (r_stretch == StMax) begin
               w_state_nxt   = StIdle;
               w_stretch_nxt = '0;
            end else begin
               w_stretch_nxt = r_stretch + SW'(1);
            end
         end
         StIdle: begin
            w_stretch_nxt = '0;
            if (r_rise[RST_CH]) begin
               w_state_nxt = StHold;
            end
         end
         StHold: begin
            // Counter saturates; leaving needs both the minimum width and a released button.
            if (r_stretch != StMax) begin
               w_stretch_nxt = r_stretch + SW'(1);
            end else if (!r_level[RST_CH]) begin
               w_state_nxt   = StIdle;
               w_stretch_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = StPwr;
            w_stretch_nxt = '0;
         end
      endcase
   end

   assign o_level      = r_level;
   assign o_rise       = r_rise;
   assign o_fall       = r_fall;
   assign o_any_change = |(r_rise | r_fall);
   assign o_rst_req    = (r_state != StIdle);

endmodule

// File: tb/tb_io_conditioner.sv
// Testbench for io_conditioner (N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=0011,
// RST_CH=0, RST_STRETCH=3). Stimulus pushes expected pulses and rst_req transitions into
// queues; a negedge monitor pops and compares whenever the DUT shows a pulse or rst_req moves.
module tb_io_conditioner;

   localparam int unsigned L = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_raw;
   logic [3:0] level;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       any_change;
   logic       rst_req;

   io_conditioner #(
      .N               (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (4'b0011),
      .RST_CH          (0),
      .RST_STRETCH     (3)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_in_raw     (in_raw),
      .o_level      (level),
      .o_rise       (rise),
      .o_fall       (fall),
      .o_any_change (any_change),
      .o_rst_req    (rst_req)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic [3:0] r;
      logic [3:0] f;
      logic [3:0] l;
   } pulse_t;

   typedef struct {
      int   cyc;
      logic v;
   } rq_t;

   pulse_t pq[$];
   rq_t    rq[$];
   logic   prev_rq = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_pulse(input int c, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] l);
      pulse_t e;
      e.cyc = c;
      e.r   = r;
      e.f   = f;
      e.l   = l;
      pq.push_back(e);
   endtask

   task automatic exp_rq(input int c, input logic v);
      rq_t e;
      e.cyc = c;
      e.v   = v;
      rq.push_back(e);
   endtask

   task automatic quiet(input string name, input logic [3:0] l);
      chk({name, "_level"}, level, l);
      chk({name, "_any_change"}, any_change, 1'b0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (any_change !== 1'b0 || rise !== 4'b0 || fall !== 4'b0) begin
         if (pq.size() == 0) begin
            chk("unexpected_pulse", {rise, fall}, 8'h00);
         end else begin
            pulse_t e;
            e = pq.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_rise", rise, e.r);
            chk("pulse_fall", fall, e.f);
            chk("pulse_level", level, e.l);
            chk("pulse_any_change", any_change, 1'b1);
         end
      end
      if (rst_req !== prev_rq) begin
         if (rq.size() == 0) begin
            chk("unexpected_rst_req", rst_req, prev_rq);
         end else begin
            rq_t e;
            e = rq.pop_front();
            chk("rst_req_cycle", cyc, e.cyc);
            chk("rst_req_value", rst_req, e.v);
         end
         prev_rq = rst_req;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      rst    = 1'b1;
      in_raw = 4'b0011;

      // Power-on: two reset edges, then release
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_level", level, 4'b0000);
      chk("reset_rise", rise, 4'b0000);
      chk("reset_fall", fall, 4'b0000);
      chk("reset_any_change", any_change, 1'b0);
      chk("reset_rst_req", rst_req, 1'b1);
      exp_rq(cyc + 3, 1'b0);
      rst = 1'b0;
      wait_cyc(4);
      quiet("after_por", 4'b0000);
      chk("rst_req_idle", rst_req, 1'b0);

      // Clean rise then fall on channel 2
      c = cyc;
      in_raw = 4'b0111;
      exp_pulse(c + L, 4'b0100, 4'b0000, 4'b0100);
      wait_cyc(10);
      quiet("clean_high", 4'b0100);
      c = cyc;
      in_raw = 4'b0011;
      exp_pulse(c + L, 4'b0000, 4'b0100, 4'b0000);
      wait_cyc(10);
      quiet("clean_low", 4'b0000);

      // Glitches: 3 high; then 3 high / 1 low / 3 high
      in_raw = 4'b0111;
      wait_cyc(3);
      in_raw = 4'b0011;
      wait_cyc(8);
      quiet("glitch_3", 4'b0000);
      in_raw = 4'b0111;
      wait_cyc(3);
      in_raw = 4'b0011;
      wait_cyc(1);
      in_raw = 4'b0111;
      wait_cyc(3);
      in_raw = 4'b0011;
      wait_cyc(8);
      quiet("glitch_313", 4'b0000);

      // Short press on reset channel (active-low): button release fall outlasts the stretch
      c = cyc;
      in_raw = 4'b0010;
      exp_pulse(c + L, 4'b0001, 4'b0000, 4'b0001);
      exp_rq(c + L + 1, 1'b1);
      wait_cyc(6);
      in_raw = 4'b0011;
      exp_pulse(c + 6 + L, 4'b0000, 4'b0001, 4'b0000);
      exp_rq(c + 6 + L + 1, 1'b0);
      wait_cyc(10);
      quiet("short_press", 4'b0000);

      // Long press: 20 cycles
      c = cyc;
      in_raw = 4'b0010;
      exp_pulse(c + L, 4'b0001, 4'b0000, 4'b0001);
      exp_rq(c + L + 1, 1'b1);
      wait_cyc(20);
      in_raw = 4'b0011;
      exp_pulse(c + 20 + L, 4'b0000, 4'b0001, 4'b0000);
      exp_rq(c + 20 + L + 1, 1'b0);
      wait_cyc(10);
      quiet("long_press", 4'b0000);

      // Simultaneous rise on channels 2 and 3
      c = cyc;
      in_raw = 4'b1111;
      exp_pulse(c + L, 4'b1100, 4'b0000, 4'b1100);
      wait_cyc(10);
      quiet("sim_rise", 4'b1100);

      // Mixed: channel 1 (active-low) rises while channel 2 falls
      c = cyc;
      in_raw = 4'b1001;
      exp_pulse(c + L, 4'b0010, 4'b0100, 4'b1010);
      wait_cyc(10);
      quiet("mixed", 4'b1010);

      // Mid-count reset at edge 4 of a pending channel-2 change; active levels drop silently
      c = cyc;
      in_raw = 4'b1101;
      wait_cyc(3);
      rst = 1'b1;
      exp_rq(c + 4, 1'b1);
      wait_cyc(1);
      chk("midrst_level", level, 4'b0000);
      chk("midrst_fall", fall, 4'b0000);
      rst = 1'b0;
      exp_rq(c + 4 + 3, 1'b0);
      exp_pulse(c + 4 + L, 4'b1110, 4'b0000, 4'b1110);
      wait_cyc(12);
      quiet("after_midrst", 4'b1110);

      chk("pulse_queue_drained", pq.size(), 0);
      chk("rst_req_queue_drained", rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
